// File: rtl/arm_dp_sequencer.sv
// Purpose: fetch/decode/execute/writeback sequencer for ARM register-form data-processing ops.
// Latency: executed instruction 4 cycles (fetch accept, decode, execute, writeback); skipped/undefined 2.
// Backpressure: fetch stalls in FETCH with MEM_REQ held high until MEM_RDY; no other stalls.
//
// Ports:
//   Clk, RESET           clock and synchronous active-high reset
//   INSTR, MEM_RDY       instruction word and memory ready for the fetch handshake
//   PCout, Pcin, LOADPC  current PC in, next PC out, PC load strobe (fetch accept cycle)
//   FLAGS_OUT, FLAGS     ALU flag result in, architectural NZCV out
//   MEM_REQ              fetch request
//   RSLCT, OP, S         register selects, ALU opcode, ALU set-flags
//   ALU_OUT, LOAD        ALU output enable, register-file write strobe for Rd
//   UNDEF                one-cycle pulse on an unsupported instruction
module arm_dp_sequencer #(
  parameter logic [4:0]  IDLE_OP = 5'd16,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic [31:0] INSTR,
  input  logic        MEM_RDY,
  input  logic [31:0] PCout,
  input  logic [3:0]  FLAGS_OUT,
  output logic        MEM_REQ,
  output logic [31:0] Pcin,
  output logic        LOADPC,
  output logic [19:0] RSLCT,
  output logic [4:0]  OP,
  output logic        S,
  output logic        ALU_OUT,
  output logic        LOAD,
  output logic [3:0]  FLAGS,
  output logic        UNDEF
);

  typedef enum logic [1:0] {
    ST_FETCH     = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ir_q;
  logic [3:0]  flags_q;

  // Instruction fields
  logic [3:0]  cond;
  logic [3:0]  opc;
  logic [3:0]  rn, rd, rs, rm;
  logic        is_test;      // TST/TEQ/CMP/CMN: no Rd write, always set flags
  logic        set_flags;
  logic        form_ok;
  logic        is_undef;
  logic        cond_pass;
  logic [19:0] dp_rslct;
  logic        flag_n, flag_z, flag_c, flag_v;

  // Shift type/amount bits [7:5] go straight to the shifter from the register
  // file path; the sequencer itself has no decision that depends on them.
  logic        unused_shift_bits;

  assign cond      = ir_q[31:28];
  assign opc       = ir_q[24:21];
  assign rn        = ir_q[19:16];
  assign rd        = ir_q[15:12];
  assign rs        = ir_q[11:8];
  assign rm        = ir_q[3:0];
  assign is_test   = (opc[3:2] == 2'b10);
  assign set_flags = ir_q[20] | is_test;
  assign form_ok   = (ir_q[27:25] == 3'b000) && !ir_q[4];
  // Writing the PC through the ALU path is not supported by this datapath.
  assign is_undef  = !form_ok || ((rd == 4'hF) && !is_test);
  assign dp_rslct  = {rn, rd, rs, rm, rn};
  assign unused_shift_bits = ^ir_q[7:5];

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
  assign FLAGS = flags_q;

  // ARM condition evaluation; 4'b1111 (NV) never passes.
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = !flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = !flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = !flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = !flag_v;
      4'h8: cond_pass = flag_c && !flag_z;
      4'h9: cond_pass = !flag_c || flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = !flag_z && (flag_n == flag_v);
      4'hD: cond_pass = flag_z || (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH && MEM_RDY) begin
        ir_q <= INSTR;
      end
      if (state_q == ST_WRITEBACK && set_flags) begin
        flags_q <= FLAGS_OUT;
      end
    end
  end

  // Next state and outputs. Outputs are held at their reset values while
  // RESET is high so a reset cycle never strobes LOAD/LOADPC or requests.
  always_comb begin
    state_d = state_q;
    MEM_REQ = 1'b0;
    Pcin    = '0;
    LOADPC  = 1'b0;
    RSLCT   = '0;
    OP      = IDLE_OP;
    S       = 1'b0;
    ALU_OUT = 1'b0;
    LOAD    = 1'b0;
    UNDEF   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (MEM_RDY) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (!cond_pass || is_undef) state_d = ST_FETCH;
        else                        state_d = ST_EXECUTE;
      end
      ST_EXECUTE:   state_d = ST_WRITEBACK;
      ST_WRITEBACK: state_d = ST_FETCH;
      default:      state_d = ST_FETCH;
    endcase

    if (!RESET) begin
      case (state_q)
        ST_FETCH: begin
          MEM_REQ = 1'b1;
          Pcin    = PCout + PC_STEP;
          LOADPC  = MEM_RDY;
        end
        ST_DECODE: begin
          // A failed condition turns even an unsupported encoding into a no-op.
          UNDEF = cond_pass && is_undef;
        end
        ST_EXECUTE, ST_WRITEBACK: begin
          RSLCT   = dp_rslct;
          OP      = {1'b0, opc};
          S       = set_flags;
          ALU_OUT = 1'b1;
          LOAD    = (state_q == ST_WRITEBACK) && !is_test;
        end
        default: ;
      endcase
    end
  end

endmodule
